// File: rtl/cnt_checker.sv
// Lockstep checker for a universal up/down counter: runs a golden model of the
// counter and compares it against the observed q/max/min every checked cycle.
module cnt_checker #(
  parameter int N           = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         chk_en,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic         syn_clr,
  input  logic         dut_rst,
  input  logic [N-1:0] d,
  input  logic [N-1:0] q_dut,
  input  logic         max_tick_dut,
  input  logic         min_tick_dut,
  output logic         err,
  output logic [15:0]  err_cnt,
  output logic [15:0]  chk_cnt,
  output logic [N-1:0] first_exp,
  output logic [N-1:0] first_got,
  output logic [15:0]  first_cyc,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, CHECK = 2'd2, FAIL = 2'd3} state_t;

  localparam logic [N-1:0] ZERO = {N{1'b0}};
  localparam logic [N-1:0] ONES = {N{1'b1}};
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'h0001;
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   q_ref_q, q_ref_d;
  logic           err_q, err_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [15:0]    chk_cnt_q, chk_cnt_d;
  logic [N-1:0]   first_exp_q, first_exp_d;
  logic [N-1:0]   first_got_q, first_got_d;
  logic [15:0]    first_cyc_q, first_cyc_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   ref_base_s, ref_next_s;
  logic           cmp_valid_s, mismatch_s;

  // In SYNC the model is seeded from the counter's present value, so the
  // controls applied at that edge advance both sides identically.
  always_comb begin
    ref_base_s = (state_q == SYNC) ? q_dut : q_ref_q;
    if (dut_rst) begin
      ref_next_s = ZERO;
    end else if (syn_clr) begin
      ref_next_s = ZERO;
    end else if (load) begin
      ref_next_s = d;
    end else if (en) begin
      ref_next_s = up ? (ref_base_s + ONE) : (ref_base_s - ONE);
    end else begin
      ref_next_s = ref_base_s;
    end
  end

  always_comb begin
    cmp_valid_s = (state_q == CHECK) && chk_en && !dut_rst;
    mismatch_s  = (q_dut != q_ref_q)
               || (max_tick_dut != (q_ref_q == ONES))
               || (min_tick_dut != (q_ref_q == ZERO));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = chk_en ? SYNC : IDLE;
      SYNC:  state_d = CHECK;
      CHECK: begin
        if (!chk_en) begin
          state_d = IDLE;
        end else if (STOP_ON_ERR && cmp_valid_s && mismatch_s) begin
          state_d = FAIL;
        end else begin
          state_d = CHECK;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_ref_d     = q_ref_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    first_cyc_d = first_cyc_q;
    busy_d      = (state_d == CHECK);
    if ((state_q == SYNC) || (state_q == CHECK)) begin
      q_ref_d = ref_next_s;
    end else begin
      q_ref_d = q_ref_q;
    end
    if (cmp_valid_s) begin
      chk_cnt_d = sat_inc(chk_cnt_q);
      if (mismatch_s) begin
        err_d     = 1'b1;
        err_cnt_d = sat_inc(err_cnt_q);
        if (!err_q) begin
          first_exp_d = q_ref_q;
          first_got_d = q_dut;
          first_cyc_d = chk_cnt_q;
        end else begin
          first_exp_d = first_exp_q;
        end
      end else begin
        err_d = err_q;
      end
    end else begin
      chk_cnt_d = chk_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_ref_q     <= ZERO;
      err_q       <= 1'b0;
      err_cnt_q   <= 16'h0000;
      chk_cnt_q   <= 16'h0000;
      first_exp_q <= ZERO;
      first_got_q <= ZERO;
      first_cyc_q <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      q_ref_q     <= q_ref_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      first_cyc_q <= first_cyc_d;
      busy_q      <= busy_d;
    end
  end

  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign chk_cnt   = chk_cnt_q;
  assign first_exp = first_exp_q;
  assign first_got = first_got_q;
  assign first_cyc = first_cyc_q;
  assign busy      = busy_q;

endmodule

// File: doc/cnt_checker.md
# cnt_checker

- Self-checking monitor that sits directly downstream of the counter stimulus generator and the universal up/down counter it drives.
- Samples the same control lines the counter receives: enable, direction, load, sync clear, load data and the counter's async-clear line.
- Runs a golden counter model in lockstep and compares it every cycle against the counter's `q`, `max_tick` and `min_tick`.
- Reports a sticky error, saturating mismatch/check counts, and a snapshot of the first failure.

## Interface

Parameters:
- `N`, 8: counter width.
- `STOP_ON_ERR`, 0: 1 freezes checking at the first mismatch; 0 keeps checking.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `chk_en` input 1: 1 arms and runs checking; 0 returns to IDLE.
- `en` input 1: counter enable, as driven to the counter.
- `up` input 1: direction; 1 counts up, 0 counts down.
- `load` input 1: parallel load, as driven to the counter.
- `syn_clr` input 1: synchronous clear, as driven to the counter.
- `dut_rst` input 1: the counter's asynchronous clear line, sampled here.
- `d` input N: load data.
- `q_dut` input N: counter output.
- `max_tick_dut` input 1: counter max flag.
- `min_tick_dut` input 1: counter min flag.
- `err` output 1: sticky mismatch flag.
- `err_cnt` output 16: mismatch count, saturating at 16'hFFFF.
- `chk_cnt` output 16: compared-cycle count, saturating at 16'hFFFF.
- `first_exp` output N: model value at the first mismatch.
- `first_got` output N: `q_dut` at the first mismatch.
- `first_cyc` output 16: `chk_cnt` value at the first mismatch.
- `busy` output 1: 1 while in CHECK.

## Operation

Golden model `q_ref`, N bits, updated on every edge in SYNC and CHECK. Priority, highest first:
- `dut_rst` = 1 → 0.
- `syn_clr` → 0.
- `load` → `d`.
- `en` with `up` → `q_ref`+1, modulo 2^N (all-ones wraps to 0).
- `en` with `!up` → `q_ref`−1, modulo 2^N (0 wraps to all-ones).
- otherwise hold.

Expected flags:
- `max_ref` = (`q_ref` == all-ones).
- `min_ref` = (`q_ref` == 0).

FSM states and transitions:
- IDLE: no compares. Goes to SYNC when `chk_en` = 1.
- SYNC: lasts one cycle. `q_ref` ← `q_dut` to align with the counter's current state; no compare this cycle. Goes to CHECK.
- CHECK: compare every cycle (see below).
  - Goes to FAIL on a mismatch when `STOP_ON_ERR` = 1.
  - Goes to IDLE when `chk_en` = 0.
- FAIL: `q_ref` and all counters frozen; `busy` = 0. Left only by `reset`.

Compare rule in CHECK:
- Mismatch = (`q_dut` != `q_ref`) OR (`max_tick_dut` != `max_ref`) OR (`min_tick_dut` != `min_ref`).
- Both sides are the values present before the edge.
- A cycle with `dut_rst` = 1 is not compared and not counted in `chk_cnt`; `q_ref` still resets.

Per compared cycle:
- `chk_cnt`+1.
- On mismatch: `err_cnt`+1 and `err` ← 1.
- On the first mismatch only (`err` was 0): capture `first_exp` = `q_ref`, `first_got` = `q_dut`, `first_cyc` = `chk_cnt` (pre-increment value).

Counter and flag persistence:
- `chk_en` dropping to 0 does not clear `err`, the counters or the snapshot; only `reset` clears them.
- Re-arming goes through SYNC again.

## Timing

- `reset` = 0 at an edge forces:
  - state IDLE;
  - `q_ref`, `err`, `err_cnt`, `chk_cnt`, `first_exp`, `first_got`, `first_cyc` and `busy` all 0.
- Reset mid-CHECK aborts on that edge; there is no partial snapshot.
- Latency:
  - `chk_en` rises at edge k, sampled at edge k+1 → SYNC; first compare at edge k+2.
  - `err` is 1 on the cycle after the mismatching sample.
  - `err_cnt` is registered and updates at the same edge as `err`.
- Simultaneous controls: `syn_clr` and `load` together → clear wins. `load` and `en` together → load wins.
- Saturation: counters hold at 16'hFFFF and do not wrap. `first_cyc` captures a saturated value as-is.
- Checking stays valid across wrap-around in both directions, including the flags.
- Outputs are combinational-free: every output comes straight from a register.

## Test plan

- Reset then arm, N=8, count up 12 cycles from 0:
  - `q_dut` matches model → `err` = 0, `err_cnt` = 0, `chk_cnt` = 12.
- Count down from 3 for 6 cycles (wraps to 253), bench drives `min_tick_dut` high on the cycle with `q_dut` = 0 and `max_tick_dut` correct throughout:
  - no mismatch.
  - Repeat with the bench driving `min_tick_dut` = 0 on the cycle with `q_dut` = 0 → `err` = 1, `err_cnt` = 1.
- Load `d` = 3 with `en` = 1 the same cycle, then count up 2:
  - model expects 3, 4, 5.
  - Injected `q_dut` = 6 instead of 5 → `first_exp` = 5, `first_got` = 6, `first_cyc` = index of that cycle.
- `dut_rst` pulse mid-count at value 7:
  - that cycle is not counted;
  - next cycle expects `q` = 0 (or 1 if `en` with `up`); no mismatch.
- `STOP_ON_ERR` = 1, mismatch at cycle 4, then 3 further mismatches:
  - FSM in FAIL, `err_cnt` = 1, `chk_cnt` frozen at 5, `busy` = 0;
  - `reset` returns to IDLE with all outputs 0.
- `STOP_ON_ERR` = 0, force mismatch every cycle for 70000 cycles:
  - `err_cnt` and `chk_cnt` saturate at 16'hFFFF;
  - `first_cyc` = 0.
